secded_hsiao_pipe_decoder: RTL and testbench

//  Parametrised, 2-stage pipelined Hsiao SECDED checker/corrector for memory read paths.

---
 rtl/secded_hsiao_pipe_decoder.sv | 168 ++++++++++++++++
 tb/tb_secded_hsiao_pipe_decoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_hsiao_pipe_decoder.sv
// Two-stage pipelined Hsiao SECDED checker/corrector with valid/ready on both sides,
// saturating single/double error counters and a sticky first-uncorrectable-error log.
module secded_hsiao_pipe_decoder #(
  parameter int DATA_W = 64,
  parameter int PAR_W  = 8,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W+PAR_W-1:0] in_code,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    correct_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_sb,
  output logic                    out_db,
  output logic [PAR_W-1:0]        out_syndrome,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        cnt_sb,
  output logic [CNT_W-1:0]        cnt_db,
  output logic                    log_valid,
  output logic [TAG_W-1:0]        log_tag,
  output logic [PAR_W-1:0]        log_syndrome
);

  localparam int CODE_W = DATA_W + PAR_W;

  function automatic int popcnt(input int v);
    int n;
    n = 0;
    for (int b = 0; b < 32; b++) n = n + (v[b] ? 1 : 0);
    return n;
  endfunction

  function automatic int odd_code_count();
    int n;
    n = 0;
    for (int v = 0; v < (1 << PAR_W); v++)
      if (popcnt(v) >= 3 && (popcnt(v) % 2) == 1) n++;
    return n;
  endfunction

  // Data columns: all weight-3 codes ascending, then weight-5, weight-7, ...
  function automatic logic [DATA_W*PAR_W-1:0] h_cols();
    logic [DATA_W*PAR_W-1:0] h;
    int idx;
    h   = '0;
    idx = 0;
    for (int w = 3; w <= PAR_W; w += 2)
      for (int v = 0; v < (1 << PAR_W); v++)
        if (popcnt(v) == w && idx < DATA_W) begin
          h[idx*PAR_W +: PAR_W] = v[PAR_W-1:0];
          idx++;
        end
    return h;
  endfunction

  localparam logic [DATA_W*PAR_W-1:0] H_COLS = h_cols();

  if (odd_code_count() < DATA_W) begin : g_bad_par_w
    $error("PAR_W has too few odd-weight codes to cover DATA_W data columns");
  end

  function automatic logic [PAR_W-1:0] calc_syn(input logic [CODE_W-1:0] code);
    logic [PAR_W-1:0] s;
    s = code[CODE_W-1 -: PAR_W];
    for (int i = 0; i < DATA_W; i++)
      if (code[i]) s = s ^ H_COLS[i*PAR_W +: PAR_W];
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic                vld_p1, vld_p2;
  logic [DATA_W-1:0]   data_p1;
  logic [TAG_W-1:0]    tag_p1;
  logic [PAR_W-1:0]    syn_p1;
  logic                cen_p1;
  logic                accept, s2_load, out_hs;
  logic [DATA_W-1:0]   flip, dec_data;
  logic                dec_sb, dec_db;

  assign s2_load   = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready  = !rst && (!vld_p1 || s2_load);
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p2;
  assign out_hs    = vld_p2 && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (accept)       vld_p1 <= 1'b1;
      else if (s2_load) vld_p1 <= 1'b0;
      if (s2_load)        vld_p2 <= 1'b1;
      else if (out_ready) vld_p2 <= 1'b0;
    end
  end

  // ---- stage 1: capture word, tag, syndrome and correction mode ----
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1 <= in_code[DATA_W-1:0];
      tag_p1  <= in_tag;
      syn_p1  <= calc_syn(in_code);
      cen_p1  <= correct_en;
    end
  end

  always_comb begin
    flip = '0;
    for (int i = 0; i < DATA_W; i++)
      flip[i] = (syn_p1 == H_COLS[i*PAR_W +: PAR_W]);
    // a one-hot syndrome is a check-bit hit: single error, data left alone
    dec_sb   = (^syn_p1) && ((|flip) || $onehot(syn_p1));
    dec_db   = (|syn_p1) && !dec_sb;
    dec_data = (dec_sb && cen_p1) ? (data_p1 ^ flip) : data_p1;
  end

  // ---- stage 2: decoded result, held while downstream stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data     <= '0;
      out_tag      <= '0;
      out_sb       <= 1'b0;
      out_db       <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_load) begin
      out_data     <= dec_data;
      out_tag      <= tag_p1;
      out_sb       <= dec_sb;
      out_db       <= dec_db;
      out_syndrome <= syn_p1;
    end
  end

  // Statistics follow delivered results; a clear wins over a same-cycle delivery.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_sb    <= '0;
      cnt_db    <= '0;
      log_valid <= 1'b0;
      if (rst) begin
        log_tag      <= '0;
        log_syndrome <= '0;
      end
    end else if (out_hs) begin
      if (out_sb) cnt_sb <= sat_inc(cnt_sb);
      if (out_db) begin
        cnt_db <= sat_inc(cnt_db);
        if (!log_valid) begin
          log_valid    <= 1'b1;
          log_tag      <= out_tag;
          log_syndrome <= out_syndrome;
        end
      end
    end
  end

endmodule

// File: tb/tb_secded_hsiao_pipe_decoder.sv
// Bench for secded_hsiao_pipe_decoder: table vectors, backpressure, counter/log and reset corners,
// with a queue scoreboard and a cycle-by-cycle counter/log model.
module tb_secded_hsiao_pipe_decoder;
  localparam int DATA_W = 64, PAR_W = 8, TAG_W = 8, CNT_W = 2;
  localparam int CODE_W = DATA_W + PAR_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0, in_ready, correct_en = 1'b1;
  logic [CODE_W-1:0]  in_code = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid, out_ready = 1'b1, out_sb, out_db;
  logic [DATA_W-1:0]  out_data;
  logic [TAG_W-1:0]   out_tag, log_tag;
  logic [PAR_W-1:0]   out_syndrome, log_syndrome;
  logic               cnt_clr = 1'b0, log_valid;
  logic [CNT_W-1:0]   cnt_sb, cnt_db;

  always #5 clk = ~clk;

  secded_hsiao_pipe_decoder #(.DATA_W(DATA_W), .PAR_W(PAR_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_tag(in_tag), .correct_en(correct_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_sb(out_sb), .out_db(out_db),
    .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .cnt_sb(cnt_sb), .cnt_db(cnt_db),
    .log_valid(log_valid), .log_tag(log_tag), .log_syndrome(log_syndrome));

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              sb;
    logic              db;
    logic [PAR_W-1:0]  syn;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CODE_W-1:0] flip;
    logic [TAG_W-1:0]  tag;
    logic              cen;
    exp_t              e;
  } vec_t;

  exp_t             sbq[$];
  vec_t             tbl[11];
  logic [PAR_W-1:0] cols[DATA_W];
  int               checks = 0, errors = 0;
  logic             mon_en = 1'b0, rnd_run = 1'b0;
  logic [CNT_W-1:0] m_sb = '0, m_db = '0;
  logic             m_lv = 1'b0;
  logic [TAG_W-1:0] m_ltag = '0;
  logic [PAR_W-1:0] m_lsyn = '0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PAR_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) if (d[i]) p = p ^ cols[i];
    return p;
  endfunction

  function automatic exp_t model(input logic [CODE_W-1:0] code, input logic [TAG_W-1:0] tag,
                                 input logic cen);
    exp_t e;
    int   hit;
    e.data = code[DATA_W-1:0];
    e.syn  = code[CODE_W-1 -: PAR_W] ^ encode(code[DATA_W-1:0]);
    e.tag  = tag;
    e.sb   = 1'b0;
    e.db   = 1'b0;
    hit    = -1;
    for (int i = 0; i < DATA_W; i++) if (cols[i] == e.syn) hit = i;
    if (e.syn != '0) begin
      if ($countones(e.syn) == 1) e.sb = 1'b1;
      else if (hit >= 0) begin
        e.sb = 1'b1;
        if (cen) e.data[hit] = ~e.data[hit];
      end else e.db = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] m_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Scoreboard and counter/log model; inputs change only just after posedge.
  always @(negedge clk) begin
    exp_t e;
    logic hs_sb, hs_db;
    if (mon_en) begin
      chk("cnt_sb", cnt_sb, m_sb);
      chk("cnt_db", cnt_db, m_db);
      chk("log_valid", log_valid, m_lv);
      if (m_lv) begin
        chk("log_tag", log_tag, m_ltag);
        chk("log_syndrome", log_syndrome, m_lsyn);
      end
    end
    hs_sb = 1'b0;
    hs_db = 1'b0;
    if (rst) begin
      m_sb = '0; m_db = '0; m_lv = 1'b0; m_ltag = '0; m_lsyn = '0;
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_tag", out_tag, e.tag);
          chk("out_sb", out_sb, e.sb);
          chk("out_db", out_db, e.db);
          chk("out_syndrome", out_syndrome, e.syn);
          hs_sb = e.sb;
          hs_db = e.db;
        end
      end
      if (cnt_clr) begin
        m_sb = '0; m_db = '0; m_lv = 1'b0;
      end else begin
        if (hs_sb) m_sb = m_inc(m_sb);
        if (hs_db) begin
          m_db = m_inc(m_db);
          if (!m_lv) begin
            m_lv = 1'b1; m_ltag = e.tag; m_lsyn = e.syn;
          end
        end
      end
    end
  end

  task automatic put(input logic [CODE_W-1:0] code, input logic [TAG_W-1:0] tag, input logic cen,
                     input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1; in_code = code; in_tag = tag; correct_en = cen;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("put_accept", in_ready, 1);
    if (in_ready) sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  function automatic vec_t mk(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] f,
                              input logic [TAG_W-1:0] t, input logic c, input logic [DATA_W-1:0] ed,
                              input logic sb, input logic db, input logic [PAR_W-1:0] syn);
    vec_t v;
    v.data = d; v.flip = f; v.tag = t; v.cen = c;
    v.e.data = ed; v.e.tag = t; v.e.sb = sb; v.e.db = db; v.e.syn = syn;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] dd, w[3];
    logic [CODE_W-1:0] code, wc[3];
    exp_t              e;
    int                n, k, b1;
    logic [7:0]        v8;

    n = 0;
    for (int wgt = 3; wgt <= PAR_W; wgt += 2)
      for (int v = 0; v < 256; v++) begin
        v8 = v[7:0];
        if ($countones(v8) == wgt && n < DATA_W) begin
          cols[n] = v8;
          n++;
        end
      end
    dd = 64'h0123_4567_89AB_CDEF;

    tbl[0]  = mk(dd,    '0,             8'h30, 1'b1, dd,    1'b0, 1'b0, 8'h00);
    tbl[1]  = mk('0,    72'h1,          8'h31, 1'b1, '0,    1'b1, 1'b0, 8'h07);
    tbl[2]  = mk('0,    72'h1,          8'h32, 1'b0, 64'h1, 1'b1, 1'b0, 8'h07);
    tbl[3]  = mk('0,    72'h3,          8'h33, 1'b1, 64'h3, 1'b0, 1'b1, 8'h0C);
    tbl[4]  = mk('0,    72'h1 << 67,    8'h34, 1'b1, '0,    1'b1, 1'b0, 8'h08);
    tbl[5]  = mk('0,    72'h8F << 64,   8'h35, 1'b1, '0,    1'b0, 1'b1, 8'h8F);
    tbl[6]  = mk('0,    72'h7F << 64,   8'h36, 1'b1, '0,    1'b0, 1'b1, 8'h7F);
    tbl[7]  = mk(dd,    72'h1 << 63,    8'h37, 1'b1, dd,    1'b1, 1'b0, 8'h57);
    tbl[8]  = mk('0,    72'h1 << 56,    8'h38, 1'b1, '0,    1'b1, 1'b0, 8'h1F);
    tbl[9]  = mk('1,    '0,             8'h39, 1'b1, '1,    1'b0, 1'b0, 8'h00);
    tbl[10] = mk('0,    72'h1 << 56,    8'h3A, 1'b0, 64'h1 << 56, 1'b1, 1'b0, 8'h1F);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_flags", {out_sb, out_db}, 0);
    chk("rst_out_syndrome", out_syndrome, 0);
    chk("rst_cnt", {cnt_sb, cnt_db}, 0);
    chk("rst_log", {log_valid, log_tag, log_syndrome}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // clean word, two-cycle latency
    put({encode(dd), dd}, 8'hA5, 1'b1, tbl[0].e.tag == 8'h30 ? model({encode(dd), dd}, 8'hA5, 1'b1) : e);
    @(negedge clk);
    chk("lat_cycle1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_out_valid", out_valid, 1);
    chk("lat_out_data", out_data, dd);
    @(posedge clk); #1;
    drain();

    // table vectors, back to back
    pulse_clr();
    foreach (tbl[i]) begin
      code = {encode(tbl[i].data), tbl[i].data} ^ tbl[i].flip;
      put(code, tbl[i].tag, tbl[i].cen, tbl[i].e);
    end
    drain();
    @(negedge clk);
    chk("tbl_log_valid", log_valid, 1);
    chk("tbl_log_tag_first", log_tag, 8'h33);
    chk("tbl_log_syn_first", log_syndrome, 8'h0C);
    chk("tbl_cnt_sb_sat", cnt_sb, 3);
    chk("tbl_cnt_db_sat", cnt_db, 3);
    @(posedge clk); #1;

    // backpressure: two words buffered, then input stalls
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      w[i]  = {$urandom, $urandom};
      wc[i] = {encode(w[i]), w[i]} ^ (72'h1 << (i * 20));
    end
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1; in_code = wc[0]; in_tag = 8'h50; correct_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, (c < 2) ? 1 : 0);
      if (c >= 2) begin
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_hold", out_data, w[0]);
      end
      if (in_ready) sbq.push_back(model(wc[k], 8'h50 + 8'(k), 1'b1));
      @(posedge clk); #1;
      if (in_ready == 1'b0 && k < 2 && c < 2) k = k;
      if (c < 2) begin
        k++;
        in_code = wc[k]; in_tag = 8'h50 + 8'(k);
      end
    end
    out_ready = 1'b1;
    put(wc[2], 8'h52, 1'b1, model(wc[2], 8'h52, 1'b1));
    drain();

    // randomised traffic with random downstream stalls
    rnd_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          dd   = {$urandom, $urandom};
          code = {encode(dd), dd};
          k    = $urandom_range(0, 2);
          b1   = $urandom_range(0, CODE_W - 1);
          if (k >= 1) code[b1] = ~code[b1];
          if (k == 2) code[(b1 + 1 + $urandom_range(0, CODE_W - 2)) % CODE_W] ^= 1'b1;
          correct_en = 1'($urandom_range(0, 1));
          put(code, 8'(i), correct_en, model(code, 8'(i), correct_en));
        end
        drain();
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    // clear wins over a same-cycle delivery
    pulse_clr();
    put(72'h1, 8'h60, 1'b1, model(72'h1, 8'h60, 1'b1));
    put(72'h3, 8'h61, 1'b1, model(72'h3, 8'h61, 1'b1));
    drain();
    out_ready = 1'b0;
    put(72'h3, 8'h62, 1'b1, model(72'h3, 8'h62, 1'b1));
    n = 0;
    while (!out_valid && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("clr_wait_out_valid", out_valid, 1);
    cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt_db", cnt_db, 0);
    chk("clr_log_valid", log_valid, 0);
    @(posedge clk); #1;
    drain();

    // reset with two words buffered drops both
    out_ready = 1'b0;
    put(72'h1, 8'h70, 1'b1, model(72'h1, 8'h70, 1'b1));
    put(72'h1, 8'h71, 1'b1, model(72'h1, 8'h71, 1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cnt_sb", cnt_sb, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_output", out_valid, 0);
    end
    chk("post_rst_in_ready2", in_ready, 1);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
